// File: rtl/gpio_apb_ctrl.sv
// APB-attached GPIO controller: output/direction registers, a two-flop input
// synchronizer, per-pin edge detection with selectable polarity, sticky W1C
// interrupt status and a level interrupt output.
module gpio_apb_ctrl #(
  parameter int unsigned GPIO_WIDTH = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [11:0]           PADDR,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [GPIO_WIDTH-1:0] DIR,
  output logic [GPIO_WIDTH-1:0] WDATA,
  input  logic [GPIO_WIDTH-1:0] RDATA,
  output logic                  IRQ
);

  localparam int unsigned W = GPIO_WIDTH;

  // Word offsets (PADDR[11:2]) of the register map.
  localparam logic [9:0] AddrDout    = 10'd0;
  localparam logic [9:0] AddrDir     = 10'd1;
  localparam logic [9:0] AddrDin     = 10'd2;
  localparam logic [9:0] AddrInten   = 10'd3;
  localparam logic [9:0] AddrIntpol  = 10'd4;
  localparam logic [9:0] AddrIntstat = 10'd5;

  logic [W-1:0] r_dout;
  logic [W-1:0] r_dir;
  logic [W-1:0] r_inten;
  logic [W-1:0] r_intpol;
  logic [W-1:0] r_intstat;
  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_prev;

  logic [9:0]   w_word;
  logic         w_wr_en;
  logic [W-1:0] w_wdata;
  logic [W-1:0] w_edge;
  logic [W-1:0] w_clr;
  logic [W-1:0] w_intstat_d;
  logic [W-1:0] w_rd_word;
  logic         w_unused;

  assign w_word  = PADDR[11:2];
  assign w_wr_en = PSEL & PENABLE & PWRITE;
  assign w_wdata = PWDATA[W-1:0];

  // Byte-lane bits and PWDATA bits above the GPIO width carry no meaning.
  assign w_unused = ^{PADDR[1:0], PWDATA};

  // Edge seen on the synchronized pin, polarity chosen per bit by INTPOL.
  assign w_edge = (r_intpol & r_s2 & ~r_prev) | (~r_intpol & ~r_s2 & r_prev);

  // W1C mask applied only on a committed INTSTAT write.
  assign w_clr = (w_wr_en && (w_word == AddrIntstat)) ? w_wdata : '0;

  // Clear first, then set, so a same-cycle edge wins over the W1C.
  assign w_intstat_d = (r_intstat & ~w_clr) | w_edge;

  // Software-visible control registers, committed on the APB access phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dout   <= '0;
      r_dir    <= '0;
      r_inten  <= '0;
      r_intpol <= '0;
    end else if (w_wr_en) begin
      if (w_word == AddrDout)   r_dout   <= w_wdata;
      if (w_word == AddrDir)    r_dir    <= w_wdata;
      if (w_word == AddrInten)  r_inten  <= w_wdata;
      if (w_word == AddrIntpol) r_intpol <= w_wdata;
    end
  end

  // Pin synchronizer, one-cycle history for edge detection, sticky status.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_prev    <= '0;
      r_intstat <= '0;
    end else begin
      r_s1      <= RDATA;
      r_s2      <= r_s1;
      r_prev    <= r_s2;
      r_intstat <= w_intstat_d;
    end
  end

  // Read mux: combinational from the address; zero when not a read.
  always_comb begin
    w_rd_word = '0;
    case (w_word)
      AddrDout:    w_rd_word = r_dout;
      AddrDir:     w_rd_word = r_dir;
      AddrDin:     w_rd_word = r_s2;
      AddrInten:   w_rd_word = r_inten;
      AddrIntpol:  w_rd_word = r_intpol;
      AddrIntstat: w_rd_word = r_intstat;
      default:     w_rd_word = '0;
    endcase
    PRDATA = '0;
    if (PSEL && !PWRITE) PRDATA = 32'(w_rd_word);
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign WDATA   = r_dout;
  assign DIR     = r_dir;
  assign IRQ     = |(r_intstat & r_inten);

endmodule

// File: doc/gpio_apb_ctrl.md
GPIO_APB_CTRL -- requirements
Module: gpio_apb_ctrl

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 16, number of GPIO lines (1..32).
REQ-002 SHALL have port HCLK  input  1  single clock; all state rising-edge.
REQ-003 SHALL have port HRESET  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port PSEL  input  1  APB select.
REQ-005 SHALL have port PENABLE  input  1  APB access phase.
REQ-006 SHALL have port PWRITE  input  1  1=write, 0=read.
REQ-007 SHALL have port PADDR  input  12  byte address; bits [11:2] decoded.
REQ-008 SHALL have port PWDATA  input  32  write data.
REQ-009 SHALL have port PRDATA  output  32  read data.
REQ-010 SHALL have port PREADY  output  1  tied 1, zero wait states.
REQ-011 SHALL have port PSLVERR  output  1  tied 0.
REQ-012 SHALL have port DIR  output  GPIO_WIDTH  to pad block; 1=drive pin.
REQ-013 SHALL have port WDATA  output  GPIO_WIDTH  to pad block; output levels.
REQ-014 SHALL have port RDATA  input  GPIO_WIDTH  from pad block; asynchronous pin levels, 0 on output-mode bits.
REQ-015 SHALL have port IRQ  output  1  level interrupt to NVIC.

Function
REQ-016 SHALL commit a write only when PSEL & PENABLE & PWRITE, on that HCLK edge.
REQ-017 SHALL drive PRDATA combinationally from PADDR when PSEL & ~PWRITE; 0 otherwise; unused upper bits read 0.
REQ-018 SHALL map registers: 0x00 DOUT rw; 0x04 DIR rw; 0x08 DIN ro; 0x0C INTEN rw; 0x10 INTPOL rw (1=rising, 0=falling); 0x14 INTSTAT rw1c.
REQ-019 SHALL ignore writes to DIN and to unmapped addresses; unmapped reads return 0.
REQ-020 SHALL drive WDATA = DOUT and DIR = DIR register directly from flops.
REQ-021 SHALL pass RDATA through a 2-flop synchronizer (s1, s2); DIN reads s2.
REQ-022 SHALL hold prev = s2 delayed one cycle; edge[i] = s2[i] & ~prev[i] when INTPOL[i]=1, ~s2[i] & prev[i] when INTPOL[i]=0.
REQ-023 SHALL set INTSTAT[i] on any cycle edge[i]=1, independent of INTEN.
REQ-024 SHALL clear INTSTAT[i] on an INTSTAT write with PWDATA[i]=1; writing 0 leaves bit unchanged.
REQ-025 SHALL give set priority: simultaneous edge and W1C on one bit leaves the bit 1.
REQ-026 SHALL drive IRQ = OR over i of (INTSTAT[i] & INTEN[i]), combinational from flops.
REQ-027 Latency: pin change sampled at edge N: s1 at N, s2/DIN at N+1, INTSTAT at N+2, IRQ visible after N+2.
REQ-028 SHALL not flag edges caused by INTPOL writes alone; detection uses only s2/prev transitions.

Reset
REQ-029 SHALL, while HRESET=1, asynchronously clear DOUT, DIR, INTEN, INTPOL, INTSTAT, s1, s2, prev to 0; WDATA=0, DIR=0, IRQ=0.
REQ-030 SHALL, on reset mid-transfer, discard the transfer; first post-reset access behaves as fresh.
REQ-031 SHALL not flag an edge on the first cycles after reset release, except a falling edge when INTPOL=0 (prev=0, so none) -- i.e. no spurious flag since all sync flops start at 0.

Verification
REQ-032 Write DIR=0x00FF, DOUT=0x00A5 -> DIR=0x00FF, WDATA=0x00A5 next cycle; readback 0x00FF/0x00A5.
REQ-033 RDATA 0x0000->0x0100 before edge N, INTEN=0x0100, INTPOL=0x0100 -> DIN=0x0100 after N+1, INTSTAT=0x0100 and IRQ=1 after N+2.
REQ-034 INTPOL[3]=0, RDATA[3] 1->0 -> INTSTAT=0x0008; INTEN[3]=0 keeps IRQ=0; set INTEN[3]=1 -> IRQ=1.
REQ-035 INTSTAT=0x0108, write 0x0008 to 0x14 -> INTSTAT=0x0100; same-cycle new edge on bit 3 with W1C -> bit 3 stays 1.
REQ-036 Read 0x20 -> PRDATA=0; write 0x08 with 0xFFFF -> DIN unchanged; PREADY=1, PSLVERR=0 throughout.
REQ-037 Assert HRESET mid-write with INTSTAT=0x0001 -> all registers 0, IRQ=0 immediately, without waiting for HCLK.
